// File: rtl/dic_pkg.sv
// Shared definitions for the first-stage data interconnect: mode encodings,
// mode-switch FSM states and statistics counter width.
package dic_pkg;

    localparam logic MODE_AB = 1'b0;
    localparam logic MODE_CD = 1'b1;

    localparam int STAT_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } dic_state_t;

endpackage

// File: rtl/data_interconnect_1_axis_reg_slice.sv
// Single-entry AXI-Stream register slice. It runs at full throughput because it
// can reload in the same cycle its held beat is taken.
module axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         empty
);

    assign s_tready = ~m_tvalid | m_tready;
    assign empty    = ~m_tvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
        end else if (s_tready) begin
            m_tvalid <= s_tvalid;
        end
    end

    // The data register needs no reset: it is only observed while m_tvalid is set.
    always_ff @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            m_tdata <= s_tdata;
        end
    end

endmodule

// File: rtl/data_interconnect_1.sv
// Registered F/G/H stream steering to A/B (mode 0) or C/D (mode 1), with an F
// up-converting packer on C. Optional handshake counters under DIC_STATS_EN.
//
//  state | meaning
//  RUN   | traffic flows in mode_cur
//  DRAIN | new traffic blocked; waiting for empty slices and an aligned packer
module data_interconnect_1
    import dic_pkg::*;
#(
    parameter int F_W     = 1536,
    parameter int G_W     = 1280,
    parameter int H_W     = 256,
    parameter int C_RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode_req,
    output logic                   mode_cur,
    output logic                   mode_pend,
    input  logic [F_W-1:0]         s_in_f_tdata,
    input  logic                   s_in_f_tvalid,
    output logic                   s_in_f_tready,
    input  logic [G_W-1:0]         s_in_g_tdata,
    input  logic                   s_in_g_tvalid,
    output logic                   s_in_g_tready,
    input  logic [H_W-1:0]         s_in_h_tdata,
    input  logic                   s_in_h_tvalid,
    output logic                   s_in_h_tready,
    output logic [G_W+H_W-1:0]     m_out_dic_a_tdata,
    output logic                   m_out_dic_a_tvalid,
    input  logic                   m_out_dic_a_tready,
    output logic [F_W-1:0]         m_out_dic_b_tdata,
    output logic                   m_out_dic_b_tvalid,
    input  logic                   m_out_dic_b_tready,
    output logic [F_W*C_RATIO-1:0] m_out_dic_c_tdata,
    output logic                   m_out_dic_c_tvalid,
    input  logic                   m_out_dic_c_tready,
    output logic [H_W-1:0]         m_out_dic_d_tdata,
    output logic                   m_out_dic_d_tvalid,
    input  logic                   m_out_dic_d_tready
`ifdef DIC_STATS_EN
    ,
    output logic [STAT_W-1:0]      stat_a_cnt,
    output logic [STAT_W-1:0]      stat_b_cnt,
    output logic [STAT_W-1:0]      stat_c_cnt,
    output logic [STAT_W-1:0]      stat_d_cnt
`endif
);

    localparam int A_W   = G_W + H_W;
    localparam int C_W   = F_W * C_RATIO;
    localparam int P_W   = F_W * (C_RATIO - 1);
    localparam int CNT_W = $clog2(C_RATIO);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(C_RATIO - 1);

    dic_state_t       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [P_W-1:0]   pack_q;
    logic [C_W-1:0]   c_word;

    logic run, in_ab, in_cd, last_beat, pack_hs, drained;
    logic acc_a, acc_b, acc_c, acc_d;
    logic empty_a, empty_b, empty_c, empty_d;
    logic load_a, load_b, load_c, load_d;

    always_comb begin
        run       = (state == RUN);
        in_ab     = (mode_cur == MODE_AB);
        in_cd     = (mode_cur == MODE_CD);
        last_beat = (beat_cnt == LAST_BEAT);

        s_in_g_tready = run & in_ab & acc_a & s_in_h_tvalid;
        s_in_h_tready = run & ((in_ab & acc_a & s_in_g_tvalid) | (in_cd & acc_d));
        // A partly filled packer keeps F open during DRAIN so the group can complete.
        if (in_ab) begin
            s_in_f_tready = run & acc_b;
        end else begin
            s_in_f_tready = (run | (beat_cnt != '0)) & (~last_beat | acc_c);
        end

        load_a  = in_ab & s_in_g_tvalid & s_in_g_tready;
        load_b  = in_ab & s_in_f_tvalid & s_in_f_tready;
        pack_hs = in_cd & s_in_f_tvalid & s_in_f_tready;
        load_c  = pack_hs & last_beat;
        load_d  = in_cd & s_in_h_tvalid & s_in_h_tready;

        drained = empty_a & empty_b & empty_c & empty_d & (beat_cnt == '0);
        c_word  = {s_in_f_tdata, pack_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mode_cur  <= MODE_AB;
            mode_pend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mode_req != mode_cur) begin
                        state     <= DRAIN;
                        mode_pend <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (mode_req == mode_cur) begin
                        state     <= RUN;
                        mode_pend <= 1'b0;
                    end else if (drained) begin
                        state     <= RUN;
                        mode_cur  <= ~mode_cur;
                        mode_pend <= 1'b0;
                    end
                end
                default: begin
                    state     <= RUN;
                    mode_pend <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pack_hs) begin
            if (last_beat) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    // Beat k lands at [k*F_W +: F_W]; the final beat bypasses pack_q straight into slice C.
    always_ff @(posedge clk) begin
        for (int k = 0; k < C_RATIO - 1; k++) begin
            if (pack_hs && (beat_cnt == CNT_W'(k))) begin
                pack_q[k*F_W +: F_W] <= s_in_f_tdata;
            end
        end
    end

    axis_reg_slice #(.W(A_W)) u_slice_a (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  ({s_in_g_tdata, s_in_h_tdata}),
        .s_tvalid (load_a),
        .s_tready (acc_a),
        .m_tdata  (m_out_dic_a_tdata),
        .m_tvalid (m_out_dic_a_tvalid),
        .m_tready (m_out_dic_a_tready),
        .empty    (empty_a)
    );

    axis_reg_slice #(.W(F_W)) u_slice_b (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_in_f_tdata),
        .s_tvalid (load_b),
        .s_tready (acc_b),
        .m_tdata  (m_out_dic_b_tdata),
        .m_tvalid (m_out_dic_b_tvalid),
        .m_tready (m_out_dic_b_tready),
        .empty    (empty_b)
    );

    axis_reg_slice #(.W(C_W)) u_slice_c (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (c_word),
        .s_tvalid (load_c),
        .s_tready (acc_c),
        .m_tdata  (m_out_dic_c_tdata),
        .m_tvalid (m_out_dic_c_tvalid),
        .m_tready (m_out_dic_c_tready),
        .empty    (empty_c)
    );

    axis_reg_slice #(.W(H_W)) u_slice_d (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_in_h_tdata),
        .s_tvalid (load_d),
        .s_tready (acc_d),
        .m_tdata  (m_out_dic_d_tdata),
        .m_tvalid (m_out_dic_d_tvalid),
        .m_tready (m_out_dic_d_tready),
        .empty    (empty_d)
    );

`ifdef DIC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_a_cnt <= '0;
            stat_b_cnt <= '0;
            stat_c_cnt <= '0;
            stat_d_cnt <= '0;
        end else begin
            if (m_out_dic_a_tvalid && m_out_dic_a_tready) stat_a_cnt <= stat_a_cnt + 1'b1;
            if (m_out_dic_b_tvalid && m_out_dic_b_tready) stat_b_cnt <= stat_b_cnt + 1'b1;
            if (m_out_dic_c_tvalid && m_out_dic_c_tready) stat_c_cnt <= stat_c_cnt + 1'b1;
            if (m_out_dic_d_tvalid && m_out_dic_d_tready) stat_d_cnt <= stat_d_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_interconnect_1.sv
// Directed bench for data_interconnect_1 with reduced widths (F=32, G=24, H=16, ratio 4).
module tb_data_interconnect_1;

    localparam int F_W = 32;
    localparam int G_W = 24;
    localparam int H_W = 16;
    localparam int CR  = 4;
    localparam int A_W = G_W + H_W;
    localparam int C_W = F_W * CR;

    logic clk = 1'b0;
    logic rst, mode_req, mode_cur, mode_pend;
    logic [F_W-1:0] f_tdata;
    logic           f_tvalid, f_tready;
    logic [G_W-1:0] g_tdata;
    logic           g_tvalid, g_tready;
    logic [H_W-1:0] h_tdata;
    logic           h_tvalid, h_tready;
    logic [A_W-1:0] a_tdata;
    logic           a_tvalid, a_tready;
    logic [F_W-1:0] b_tdata;
    logic           b_tvalid, b_tready;
    logic [C_W-1:0] c_tdata;
    logic           c_tvalid, c_tready;
    logic [H_W-1:0] d_tdata;
    logic           d_tvalid, d_tready;
`ifdef DIC_STATS_EN
    logic [31:0] stat_a_cnt, stat_b_cnt, stat_c_cnt, stat_d_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_interconnect_1 #(.F_W(F_W), .G_W(G_W), .H_W(H_W), .C_RATIO(CR)) dut (
        .clk(clk), .rst(rst), .mode_req(mode_req), .mode_cur(mode_cur), .mode_pend(mode_pend),
        .s_in_f_tdata(f_tdata), .s_in_f_tvalid(f_tvalid), .s_in_f_tready(f_tready),
        .s_in_g_tdata(g_tdata), .s_in_g_tvalid(g_tvalid), .s_in_g_tready(g_tready),
        .s_in_h_tdata(h_tdata), .s_in_h_tvalid(h_tvalid), .s_in_h_tready(h_tready),
        .m_out_dic_a_tdata(a_tdata), .m_out_dic_a_tvalid(a_tvalid), .m_out_dic_a_tready(a_tready),
        .m_out_dic_b_tdata(b_tdata), .m_out_dic_b_tvalid(b_tvalid), .m_out_dic_b_tready(b_tready),
        .m_out_dic_c_tdata(c_tdata), .m_out_dic_c_tvalid(c_tvalid), .m_out_dic_c_tready(c_tready),
        .m_out_dic_d_tdata(d_tdata), .m_out_dic_d_tvalid(d_tvalid), .m_out_dic_d_tready(d_tready)
`ifdef DIC_STATS_EN
        , .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt)
        , .stat_c_cnt(stat_c_cnt), .stat_d_cnt(stat_d_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mode(input logic m, input string name);
        int n = 0;
        while (mode_cur !== m && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (mode_cur !== m) begin
            errors++;
            $display("FAIL %s: mode_cur=%b after %0d cycles, want %b", name, mode_cur, n, m);
        end
    endtask

    // Sends one full group of CR F beats with values base+1..base+CR, checking F is ready each beat.
    task automatic send_group(input logic [F_W-1:0] base, input string name);
        for (int k = 1; k <= CR; k++) begin
            f_tdata  = base + F_W'(k);
            f_tvalid = 1'b1;
            #1;
            checks++;
            if (f_tready !== 1'b1) begin
                errors++;
                $display("FAIL %s_f_ready beat %0d: got %b want 1", name, k, f_tready);
            end
            step();
        end
        f_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_req = 1'b0;
        f_tvalid = 0; g_tvalid = 0; h_tvalid = 0;
        f_tdata = '0; g_tdata = '0; h_tdata = '0;
        a_tready = 1; b_tready = 1; c_tready = 1; d_tready = 1;
        step(); step();
        checks++;
        if ({mode_cur, mode_pend, a_tvalid, b_tvalid, c_tvalid, d_tvalid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_state: got %b want 000000",
                     {mode_cur, mode_pend, a_tvalid, b_tvalid, c_tvalid, d_tvalid});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ab_path();
        logic [F_W-1:0] fv[2];
        logic [G_W-1:0] gv[2];
        logic [H_W-1:0] hv[2];
        fv = '{32'h1111_1111, 32'h89AB_CDEF};
        gv = '{24'h22_2222, 24'h45_6789};
        hv = '{16'h3333, 16'hFEDC};
        for (int i = 0; i < 2; i++) begin
            f_tdata = fv[i]; g_tdata = gv[i]; h_tdata = hv[i];
            f_tvalid = 1; g_tvalid = 1; h_tvalid = 1;
            #1;
            checks++;
            if ({f_tready, g_tready, h_tready} !== 3'b111) begin
                errors++;
                $display("FAIL ab_readies beat %0d: got %b want 111", i, {f_tready, g_tready, h_tready});
            end
            step();
            checks++;
            if (a_tvalid !== 1'b1 || a_tdata !== {gv[i], hv[i]}) begin
                errors++;
                $display("FAIL a_out beat %0d: got v=%b %h want v=1 %h", i, a_tvalid, a_tdata, {gv[i], hv[i]});
            end
            checks++;
            if (b_tvalid !== 1'b1 || b_tdata !== fv[i]) begin
                errors++;
                $display("FAIL b_out beat %0d: got v=%b %h want v=1 %h", i, b_tvalid, b_tdata, fv[i]);
            end
            checks++;
            if ({c_tvalid, d_tvalid} !== 2'b00) begin
                errors++;
                $display("FAIL cd_idle_mode0 beat %0d: got %b want 00", i, {c_tvalid, d_tvalid});
            end
        end
        f_tvalid = 0; g_tvalid = 0; h_tvalid = 0;
        step();
        checks++;
        if ({a_tvalid, b_tvalid} !== 2'b00) begin
            errors++;
            $display("FAIL ab_drained: got %b want 00", {a_tvalid, b_tvalid});
        end
    endtask

    task automatic test_join_stall();
        h_tdata = 16'hABCD; h_tvalid = 1; g_tvalid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (h_tready !== 1'b0) begin
                errors++;
                $display("FAIL join_h_ready cycle %0d: got %b want 0", i, h_tready);
            end
            step();
            checks++;
            if (a_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL join_no_a cycle %0d: got %b want 0", i, a_tvalid);
            end
        end
        g_tdata = 24'h13_579B; g_tvalid = 1;
        #1;
        checks++;
        if ({g_tready, h_tready} !== 2'b11) begin
            errors++;
            $display("FAIL join_readies: got %b want 11", {g_tready, h_tready});
        end
        step();
        checks++;
        if (a_tvalid !== 1'b1 || a_tdata !== 40'h13_579B_ABCD) begin
            errors++;
            $display("FAIL join_a_out: got v=%b %h want v=1 13579babcd", a_tvalid, a_tdata);
        end
        g_tvalid = 0; h_tvalid = 0;
        step();
        checks++;
        if (a_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL join_single_beat: got %b want 0", a_tvalid);
        end
    endtask

    task automatic test_pack();
        mode_req = 1'b1;
        step();
        checks++;
        if ({mode_pend, mode_cur} !== 2'b10) begin
            errors++;
            $display("FAIL pend_after_req: got pend,cur=%b want 10", {mode_pend, mode_cur});
        end
        wait_mode(1'b1, "switch_to_cd");
        checks++;
        if (mode_pend !== 1'b0) begin
            errors++;
            $display("FAIL pend_cleared_cd: got %b want 0", mode_pend);
        end
        g_tvalid = 1; g_tdata = 24'hFFFFFF;
        #1;
        checks++;
        if (g_tready !== 1'b0) begin
            errors++;
            $display("FAIL g_blocked_mode1: got %b want 0", g_tready);
        end
        c_tready = 1;
        for (int k = 1; k <= CR; k++) begin
            f_tdata = F_W'(k); f_tvalid = 1;
            #1;
            checks++;
            if (f_tready !== 1'b1) begin
                errors++;
                $display("FAIL pack_f_ready beat %0d: got %b want 1", k, f_tready);
            end
            step();
            if (k < CR) begin
                checks++;
                if (c_tvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL pack_c_early beat %0d: got %b want 0", k, c_tvalid);
                end
            end
        end
        checks++;
        if (c_tvalid !== 1'b1 || c_tdata !== 128'h00000004_00000003_00000002_00000001) begin
            errors++;
            $display("FAIL pack_c_word: got v=%b %h want v=1 00000004000000030000000200000001",
                     c_tvalid, c_tdata);
        end
        checks++;
        if ({a_tvalid, b_tvalid} !== 2'b00) begin
            errors++;
            $display("FAIL ab_idle_mode1: got %b want 00", {a_tvalid, b_tvalid});
        end
        f_tvalid = 0; g_tvalid = 0;
        step();
        checks++;
        if (c_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL pack_c_taken: got %b want 0", c_tvalid);
        end
    endtask

    task automatic test_c_stall();
        logic [C_W-1:0] w1, w2;
        w1 = {32'h104, 32'h103, 32'h102, 32'h101};
        w2 = {32'h204, 32'h203, 32'h202, 32'h201};
        c_tready = 0;
        send_group(32'h100, "stall_g1");
        checks++;
        if (c_tvalid !== 1'b1 || c_tdata !== w1) begin
            errors++;
            $display("FAIL stall_w1: got v=%b %h want v=1 %h", c_tvalid, c_tdata, w1);
        end
        for (int k = 1; k < CR; k++) begin
            f_tdata = 32'h200 + F_W'(k); f_tvalid = 1;
            #1;
            checks++;
            if (f_tready !== 1'b1) begin
                errors++;
                $display("FAIL stall_g2_ready beat %0d: got %b want 1", k, f_tready);
            end
            step();
        end
        f_tdata = 32'h204; f_tvalid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (f_tready !== 1'b0) begin
                errors++;
                $display("FAIL stall_last_blocked cycle %0d: got %b want 0", i, f_tready);
            end
            checks++;
            if (c_tvalid !== 1'b1 || c_tdata !== w1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b %h want v=1 %h", i, c_tvalid, c_tdata, w1);
            end
            step();
        end
        c_tready = 1;
        #1;
        checks++;
        if (f_tready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 1", f_tready);
        end
        step();
        f_tvalid = 0;
        checks++;
        if (c_tvalid !== 1'b1 || c_tdata !== w2) begin
            errors++;
            $display("FAIL stall_w2: got v=%b %h want v=1 %h", c_tvalid, c_tdata, w2);
        end
        step();
        checks++;
        if (c_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL stall_w2_taken: got %b want 0", c_tvalid);
        end
    endtask

    task automatic test_switch_mid_group();
        c_tready = 1;
        for (int k = 1; k <= 2; k++) begin
            f_tdata = 32'h10 + F_W'(k); f_tvalid = 1;
            step();
        end
        f_tvalid = 0; mode_req = 1'b0;
        h_tdata = 16'h7777; h_tvalid = 1;
        step();
        checks++;
        if ({mode_pend, mode_cur} !== 2'b11) begin
            errors++;
            $display("FAIL midgrp_pend: got pend,cur=%b want 11", {mode_pend, mode_cur});
        end
        checks++;
        if ({f_tready, h_tready} !== 2'b10) begin
            errors++;
            $display("FAIL midgrp_drain_readies: got f,h=%b want 10", {f_tready, h_tready});
        end
        for (int k = 3; k <= 4; k++) begin
            f_tdata = 32'h10 + F_W'(k); f_tvalid = 1;
            #1;
            checks++;
            if (f_tready !== 1'b1) begin
                errors++;
                $display("FAIL midgrp_f_ready beat %0d: got %b want 1", k, f_tready);
            end
            step();
        end
        f_tvalid = 0; h_tvalid = 0;
        checks++;
        if (c_tvalid !== 1'b1 || c_tdata !== 128'h00000014_00000013_00000012_00000011 || mode_cur !== 1'b1) begin
            errors++;
            $display("FAIL midgrp_c_word: got v=%b %h cur=%b want v=1 00000014000000130000001200000011 cur=1",
                     c_tvalid, c_tdata, mode_cur);
        end
        wait_mode(1'b0, "switch_to_ab");
        checks++;
        if ({mode_pend, d_tvalid, c_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL midgrp_after_switch: got pend,d,c=%b want 000", {mode_pend, d_tvalid, c_tvalid});
        end
        f_tdata = 32'hBEEF_0001; f_tvalid = 1;
        #1;
        checks++;
        if (f_tready !== 1'b1) begin
            errors++;
            $display("FAIL midgrp_b_ready: got %b want 1", f_tready);
        end
        step();
        f_tvalid = 0;
        checks++;
        if (b_tvalid !== 1'b1 || b_tdata !== 32'hBEEF_0001) begin
            errors++;
            $display("FAIL midgrp_b_out: got v=%b %h want v=1 beef0001", b_tvalid, b_tdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        mode_req = 1'b1;
        step();
        wait_mode(1'b1, "rstmid_to_cd");
        d_tready = 0; c_tready = 1;
        f_tdata = 32'h21; f_tvalid = 1;
        h_tdata = 16'h5A5A; h_tvalid = 1;
        #1;
        checks++;
        if (h_tready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_h_ready: got %b want 1", h_tready);
        end
        step();
        h_tvalid = 0; f_tdata = 32'h22;
        step();
        f_tdata = 32'h23;
        step();
        f_tvalid = 0;
        checks++;
        if (d_tvalid !== 1'b1 || d_tdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL rstmid_d_full: got v=%b %h want v=1 5a5a", d_tvalid, d_tdata);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({mode_cur, mode_pend, a_tvalid, b_tvalid, c_tvalid, d_tvalid} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: got %b want 000000",
                     {mode_cur, mode_pend, a_tvalid, b_tvalid, c_tvalid, d_tvalid});
        end
        rst = 1'b0; d_tready = 1;
        wait_mode(1'b1, "rstmid_back_to_cd");
        send_group(32'h30, "rstmid_g");
        checks++;
        if (c_tvalid !== 1'b1 || c_tdata !== 128'h00000034_00000033_00000032_00000031) begin
            errors++;
            $display("FAIL rstmid_fresh_word: got v=%b %h want v=1 00000034000000330000003200000031",
                     c_tvalid, c_tdata);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ab_path();
        test_join_stall();
        test_pack();
        test_c_stall();
        test_switch_mid_group();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_interconnect_1.md
# data_interconnect_1

Parametrised, registered successor of the first-stage data interconnect in the poly-systolic data route. It steers the F, G and H AXI-Stream inputs to the A/B (mode 0) or C/D (mode 1) outputs, and up-converts F by a configurable ratio on the C path. Every output has a full-throughput register slice. Mode changes are applied only at a drained, beat-aligned boundary, so a transfer is never split or dropped. It sits between the input DMA fan-in and the systolic array feeders.

## Interface
Parameters:
- F_W, 1536: width of F input and B output.
- G_W, 1280: width of G input.
- H_W, 256: width of H input and D output.
- C_RATIO, 4: F beats packed per C beat; legal range 2..8.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_req  in  1  requested mode: 0 = A/B, 1 = C/D.
- mode_cur  out  1  mode currently applied.
- mode_pend  out  1  mode_req differs from mode_cur and the switch is waiting for drain.
- s_in_f_tdata/tvalid/tready  in/in/out  F_W/1/1  F stream.
- s_in_g_tdata/tvalid/tready  in/in/out  G_W/1/1  G stream.
- s_in_h_tdata/tvalid/tready  in/in/out  H_W/1/1  H stream.
- m_out_dic_a_tdata/tvalid/tready  out/out/in  G_W+H_W/1/1  A stream, data = {G,H}.
- m_out_dic_b_tdata/tvalid/tready  out/out/in  F_W/1/1  B stream.
- m_out_dic_c_tdata/tvalid/tready  out/out/in  F_W*C_RATIO/1/1  C stream.
- m_out_dic_d_tdata/tvalid/tready  out/out/in  H_W/1/1  D stream.

## Operation
- Each output has one register slice. A slice can accept when it is empty or when its output handshake fires in the same cycle.
- Mode 0, A path: G and H are joined. Both are accepted in the same cycle only when both are valid and slice A can accept. s_in_g_tready = s_in_h_tready = can_accept_A & the other input's tvalid.
- Mode 0, B path: F is passed to slice B.
- Mode 1, D path: H is passed to slice D. G is never ready.
- Mode 1, C path: F feeds the packer.
  - beat_cnt runs 0..C_RATIO-1. Beat k goes to bits [k*F_W +: F_W], so the first beat lands in the LSBs.
  - While beat_cnt < C_RATIO-1, F is ready unconditionally.
  - On the last beat, F is ready only if slice C can accept. The full word is then loaded into slice C and beat_cnt returns to 0.
- Inputs that are unused in the current mode have tready = 0. Outputs that are unused in the current mode have tvalid = 0.
- Mode switch FSM, states RUN and DRAIN:
  - RUN -> DRAIN when mode_req != mode_cur.
  - In DRAIN, all s_*_tready = 0.
  - DRAIN -> RUN when all four slices are empty and beat_cnt == 0. mode_cur toggles on that same edge.
  - If mode_req returns to mode_cur while in DRAIN, go back to RUN with no toggle.
  - A mode switch with a partially filled packer cannot complete until the packer is filled. Upstream must finish the group first; DRAIN blocks only new-mode traffic, and F stays ready to complete the group.
- Reset values: mode_cur = 0, mode_pend = 0, state RUN, beat_cnt = 0, all slices empty, all m_*_tvalid = 0. Reset mid-packet discards the partial C word.

## Timing
- A, B, D latency: 1 cycle from input handshake to m_*_tvalid.
- C latency: 1 cycle after the C_RATIO-th F handshake.
- Throughput: 1 beat per cycle on A, B and D. On C, 1 C beat per C_RATIO cycles, with no bubble when tready is held high.
- Held m_*_tdata stays stable while tvalid=1 and tready=0. tvalid never depends on the same-cycle tready.
- Mode switch costs at least 1 idle cycle. mode_pend is high from the cycle after the mode_req change until mode_cur updates.

## Configuration
- DIC_STATS_EN defined: adds four 32-bit output ports, stat_a_cnt, stat_b_cnt, stat_c_cnt and stat_d_cnt.
  - Each counts m_* handshakes, wraps at 2^32, and is cleared by rst.
- DIC_STATS_EN undefined: no counters and no stat ports are compiled.

## Structure
- Shared package dic_pkg holds:
  - mode encodings MODE_AB = 1'b0 and MODE_CD = 1'b1;
  - FSM state typedef {RUN, DRAIN};
  - STAT_W = 32.
- One sub-module, axis_reg_slice (parameter W). It is instantiated four times, once per output, and exposes an empty flag.

## Test plan
- Reset, then mode_req=0. Send F=0x1…1 and G/H beats with A/B tready=1 -> A={G,H} and B=F, each 1 cycle later. C and D stay at tvalid=0.
- Mode 0, with H valid and G not valid for 5 cycles -> s_in_h_tready=0 and no A output. When G is asserted, one A beat appears.
- Mode 1, C_RATIO=4, F beats 1,2,3,4 -> one C beat with data {4,3,2,1}, valid 1 cycle after beat 4.
- Mode 1, m_out_dic_c_tready=0 after the first C word, 8 F beats sent -> 3 beats accepted, the 4th stalled, C data held stable. Releasing tready resumes the flow with no loss.
- Mode 1 after 2 F beats, mode_req->0 -> mode_pend=1. Two more F beats complete the group and C drains, then mode_cur=0 and B traffic flows.
- rst asserted with beat_cnt=3 and slice D full -> all tvalid=0 next cycle and mode_cur=0. A fresh group of 4 F beats yields only new data.
